// File: rtl/instr_decode_pkg.sv
// Shared definitions for the instruction decode queue: default field geometry,
// instruction-width helper and a reference decoded-instruction layout.
package instr_decode_pkg;

  localparam int unsigned OPC_W_DEF       = 5;
  localparam int unsigned MODE_W_DEF      = 2;
  localparam int unsigned ADDR_W_DEF      = 4;
  localparam int unsigned OFS_W_DEF       = 4;
  localparam int unsigned BOFS_W_DEF      = 8;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned NUM_OPCODES_DEF = 24;

  // Raw word width is the concatenation of all four fields.
  function automatic int unsigned instr_width(input int unsigned opc_w, input int unsigned mode_w,
                                              input int unsigned addr_w, input int unsigned ofs_w);
    return opc_w + mode_w + addr_w + ofs_w;
  endfunction

  localparam int unsigned INSTR_W_DEF = instr_width(OPC_W_DEF, MODE_W_DEF, ADDR_W_DEF, OFS_W_DEF);

  // Decoded layout at the default geometry.
  typedef struct packed {
    logic [OPC_W_DEF-1:0]  opcode;
    logic [MODE_W_DEF-1:0] mode;
    logic [ADDR_W_DEF-1:0] addr;
    logic [BOFS_W_DEF-1:0] bofs;
  } dec_instr_t;

  function automatic logic [BOFS_W_DEF-1:0] sext_ofs(input logic [OFS_W_DEF-1:0] ofs);
    return BOFS_W_DEF'($signed(ofs));
  endfunction

  function automatic dec_instr_t decode_default(input logic [INSTR_W_DEF-1:0] instr);
    dec_instr_t d;
    d.opcode = instr[INSTR_W_DEF-1 -: OPC_W_DEF];
    d.mode   = instr[INSTR_W_DEF-OPC_W_DEF-1 -: MODE_W_DEF];
    d.addr   = instr[OFS_W_DEF+ADDR_W_DEF-1 -: ADDR_W_DEF];
    d.bofs   = sext_ofs(instr[OFS_W_DEF-1:0]);
    return d;
  endfunction

endpackage

// File: rtl/instr_decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and the execution controller.
interface instr_decode_queue_if
  import instr_decode_pkg::*;
#(
  parameter int unsigned OPC_W  = OPC_W_DEF,
  parameter int unsigned MODE_W = MODE_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned OFS_W  = OFS_W_DEF,
  parameter int unsigned BOFS_W = BOFS_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
);

  localparam int unsigned INSTR_W = instr_width(OPC_W, MODE_W, ADDR_W, OFS_W);
  localparam int unsigned OCC_W   = $clog2(DEPTH + 1);

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic               flush;
  logic               dec_valid;
  logic               dec_ready;
  logic [OPC_W-1:0]   opcode;
  logic [MODE_W-1:0]  operand_addr_mode;
  logic [ADDR_W-1:0]  operand_addr;
  logic [BOFS_W-1:0]  branch_offset_value;
  logic               illegal;
  logic               start;
  logic [OCC_W-1:0]   occupancy;

  // Decoder side.
  modport slave (
    input  instr_valid, instruction, flush, dec_ready,
    output instr_ready, dec_valid, opcode, operand_addr_mode, operand_addr,
           branch_offset_value, illegal, start, occupancy
  );

  // Fetch / execution-controller side.
  modport master (
    output instr_valid, instruction, flush, dec_ready,
    input  instr_ready, dec_valid, opcode, operand_addr_mode, operand_addr,
           branch_offset_value, illegal, start, occupancy
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO for raw instruction words; pointers wrap naturally (DEPTH power of two).
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state pointers and fill count; flush returns everything to the empty state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless outside the count window so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instr_decode_queue.sv
// Buffered instruction decoder: FIFO of raw words feeding a registered decode stage.
// Optional build macro ILLEGAL_OPCODE_CHECK_EN flags opcodes >= NUM_OPCODES.
module instr_decode_queue
  import instr_decode_pkg::*;
#(
  parameter int unsigned OPC_W       = OPC_W_DEF,
  parameter int unsigned MODE_W      = MODE_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned OFS_W       = OFS_W_DEF,
  parameter int unsigned BOFS_W      = BOFS_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned NUM_OPCODES = NUM_OPCODES_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_decode_queue_if.slave  bus
);

  localparam int unsigned INSTR_W = instr_width(OPC_W, MODE_W, ADDR_W, OFS_W);
  localparam int unsigned OCC_W   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [MODE_W-1:0] mode;
    logic [ADDR_W-1:0] addr;
    logic [BOFS_W-1:0] bofs;
    logic              illegal;
  } dec_t;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [OCC_W-1:0]   fifo_count;
  logic [INSTR_W-1:0] fifo_rdata, src;
  logic               push_ok, out_pop, load;
  logic               dec_valid_q, dec_valid_d, start_q;
  dec_t               dec_q, dec_d;

  // Ready comes from registered FIFO state only, never from dec_ready.
  assign bus.instr_ready = rst_n & ~fifo_full;
  assign push_ok = bus.instr_valid & bus.instr_ready & ~bus.flush;
  assign out_pop = dec_valid_q & bus.dec_ready;
  assign load    = ~bus.flush & (~dec_valid_q | out_pop) & (~fifo_empty | push_ok);
  // FIFO head has priority; an empty FIFO lets the incoming word bypass straight to the stage.
  assign src       = fifo_empty ? bus.instruction : fifo_rdata;
  assign fifo_pop  = load & ~fifo_empty;
  assign fifo_push = push_ok & ~(load & fifo_empty);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (fifo_push),
    .wdata (bus.instruction),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Field split and sign extension of the word about to enter the output stage.
  always_comb begin
    dec_d.opcode = src[INSTR_W-1 -: OPC_W];
    dec_d.mode   = src[INSTR_W-OPC_W-1 -: MODE_W];
    dec_d.addr   = src[OFS_W+ADDR_W-1 -: ADDR_W];
    dec_d.bofs   = BOFS_W'($signed(src[OFS_W-1:0]));
`ifdef ILLEGAL_OPCODE_CHECK_EN
    dec_d.illegal = (32'(dec_d.opcode) >= NUM_OPCODES);
`else
    dec_d.illegal = 1'b0;
`endif
  end

`ifndef ILLEGAL_OPCODE_CHECK_EN
  logic unused_num_opcodes;
  assign unused_num_opcodes = ^NUM_OPCODES;
`endif

  // Output-stage occupancy: flush empties it, a load fills it, a bare pop empties it.
  always_comb begin
    dec_valid_d = dec_valid_q;
    if (bus.flush)    dec_valid_d = 1'b0;
    else if (load)    dec_valid_d = 1'b1;
    else if (out_pop) dec_valid_d = 1'b0;
  end

  // Output stage registers; fields change only on a load so they hold through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
      start_q     <= 1'b0;
    end else begin
      dec_valid_q <= dec_valid_d;
      if (load) dec_q <= dec_d;
      start_q <= start_q | push_ok;
    end
  end

  assign bus.dec_valid           = dec_valid_q;
  assign bus.opcode              = dec_q.opcode;
  assign bus.operand_addr_mode   = dec_q.mode;
  assign bus.operand_addr        = dec_q.addr;
  assign bus.branch_offset_value = dec_q.bofs;
  assign bus.illegal             = dec_q.illegal;
  assign bus.start               = start_q;
  assign bus.occupancy           = fifo_count;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: directed scenarios plus randomized traffic.
module tb_instr_decode_queue;

  localparam int DEPTH   = 4;
  localparam int NUM_OPC = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_decode_queue_if bus ();

  instr_decode_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: every word inside the block, oldest first.
  logic [14:0] exp_q[$];
  bit          start_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_opc(input logic [14:0] w);  return int'(w) / 1024;        endfunction
  function automatic int f_mode(input logic [14:0] w); return (int'(w) / 256) % 4;   endfunction
  function automatic int f_addr(input logic [14:0] w); return (int'(w) / 16) % 16;   endfunction
  function automatic int f_bofs(input logic [14:0] w);
    int o;
    o = int'(w) % 16;
    if (o >= 8) o = o - 16;
    return o & 255;
  endfunction
  function automatic int f_illegal(input logic [14:0] w);
`ifdef ILLEGAL_OPCODE_CHECK_EN
    return (f_opc(w) >= NUM_OPC) ? 1 : 0;
`else
    return (w === 15'hx) ? 1 : 0;
`endif
  endfunction
  function automatic logic [14:0] mk(input int opc, input int mode, input int addr, input int ofs);
    return 15'(opc * 1024 + mode * 256 + addr * 16 + ofs);
  endfunction

  // Monitor: compare visible state to the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    int occ_exp;
    if (!rst_n) begin
      exp_q.delete();
      start_exp = 1'b0;
    end else begin
      occ_exp = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
      check("dec_valid", bus.dec_valid, (exp_q.size() > 0) ? 1 : 0);
      check("occupancy", bus.occupancy, occ_exp);
      check("instr_ready", bus.instr_ready, (occ_exp < DEPTH) ? 1 : 0);
      check("start", bus.start, start_exp);
      if (bus.dec_valid && exp_q.size() > 0) begin
        check("opcode", bus.opcode, f_opc(exp_q[0]));
        check("mode", bus.operand_addr_mode, f_mode(exp_q[0]));
        check("addr", bus.operand_addr, f_addr(exp_q[0]));
        check("bofs", bus.branch_offset_value, f_bofs(exp_q[0]));
        check("illegal", bus.illegal, f_illegal(exp_q[0]));
      end
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (bus.dec_valid && bus.dec_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (bus.instr_valid && bus.instr_ready) begin
          exp_q.push_back(bus.instruction);
          start_exp = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted, bounded.
  task automatic push_word(input logic [14:0] w);
    int n = 0;
    bus.instr_valid = 1'b1;
    bus.instruction = w;
    @(negedge clk);
    while (!bus.instr_ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (n >= 32) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.flush       = 1'b0;
    bus.dec_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dec_valid", bus.dec_valid, 0);
    check("rst_start", bus.start, 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", bus.instr_ready, 1);
    tick();

    // First word: one-cycle latency and field split.
    bus.dec_ready = 1'b1;
    push_word(15'b101011001101001);
    @(negedge clk);
    check("first_valid", bus.dec_valid, 1);
    check("first_opcode", bus.opcode, 32'h15);
    check("first_mode", bus.operand_addr_mode, 2);
    check("first_addr", bus.operand_addr, 6);
    check("first_bofs", bus.branch_offset_value, 32'hF9);
    check("first_start", bus.start, 1);
    tick();

    // Sign-extension boundaries.
    push_word(mk(3, 1, 2, 7));
    @(negedge clk);
    check("bofs_pos_max", bus.branch_offset_value, 32'h07);
    tick();
    push_word(mk(3, 1, 2, 8));
    @(negedge clk);
    check("bofs_neg_min", bus.branch_offset_value, 32'hF8);
    tick();

    // Stall: five words fill output stage plus all FIFO entries.
    bus.dec_ready = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) push_word(15'($urandom));
    @(negedge clk);
    check("full_occ", bus.occupancy, DEPTH);
    check("full_ready", bus.instr_ready, 0);
    tick();
    bus.instr_valid = 1'b1;
    bus.instruction = 15'($urandom);
    repeat (3) tick();
    bus.instr_valid = 1'b0;
    bus.dec_ready = 1'b1;
    repeat (7) tick();
    @(negedge clk);
    check("drained_occ", bus.occupancy, 0);
    tick();

    // Continuous stream through the bypass path.
    for (int i = 0; i < 12; i++) begin
      bus.instr_valid = 1'b1;
      bus.instruction = 15'($urandom);
      tick();
    end
    bus.instr_valid = 1'b0;
    repeat (2) tick();

    // Flush with a word offered in the same cycle.
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(15'($urandom));
    bus.instr_valid = 1'b1;
    bus.instruction = 15'h7FFF;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", bus.dec_valid, 0);
    check("flush_occ", bus.occupancy, 0);
    check("flush_start", bus.start, 1);
    tick();
    bus.dec_ready = 1'b1;
    repeat (3) tick();

    // Opcode legality boundary.
    push_word(mk(23, 0, 0, 0));
    @(negedge clk);
    check("opc23_illegal", bus.illegal, 0);
    tick();
    push_word(mk(24, 1, 1, 1));
    @(negedge clk);
    check("opc24_valid", bus.dec_valid, 1);
`ifdef ILLEGAL_OPCODE_CHECK_EN
    check("opc24_illegal", bus.illegal, 1);
`else
    check("opc24_illegal", bus.illegal, 0);
`endif
    tick();

    // Randomized traffic with a mid-stream asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.dec_valid, 0);
        check("mid_rst_ready", bus.instr_ready, 0);
        check("mid_rst_occ", bus.occupancy, 0);
        check("mid_rst_start", bus.start, 0);
        check("mid_rst_opcode", bus.opcode, 0);
        check("mid_rst_bofs", bus.branch_offset_value, 0);
        check("mid_rst_illegal", bus.illegal, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      bus.instruction = 15'($urandom);
      bus.dec_ready   = ($urandom_range(0, 2) != 0);
      bus.flush       = ($urandom_range(0, 29) == 0);
      tick();
    end
    bus.instr_valid = 1'b0;
    bus.flush = 1'b0;
    bus.dec_ready = 1'b1;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
Parametrised successor to the single-register instruction decoder. Accepts raw instruction words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Splits each word into opcode / addressing-mode / operand-address / branch-offset fields and presents them in a registered output stage with its own valid/ready handshake. Sits between instruction fetch and the crypto execution controller; adds backpressure, flush, branch-offset sign extension and a sticky start flag.

Parameters:
OPC_W, 5, opcode field width (MSB field of instruction)
MODE_W, 2, operand addressing-mode field width
ADDR_W, 4, operand address field width
OFS_W, 4, branch offset field width (LSB field, two's complement)
BOFS_W, 8, width of sign-extended branch offset output (>= OFS_W)
DEPTH, 4, FIFO entries; power of two, >= 2
NUM_OPCODES, 24, count of legal opcodes 0..NUM_OPCODES-1 (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  upstream word valid
instr_ready  out  1  FIFO can accept; equals !full, registered-state derived
instruction  in  INSTR_W  raw word, INSTR_W = OPC_W+MODE_W+ADDR_W+OFS_W (15 by default)
flush  in  1  discard all buffered and presented words
dec_valid  out  1  decoded fields valid
dec_ready  in  1  downstream consumes when dec_valid && dec_ready
opcode  out  OPC_W  instruction[INSTR_W-1 -: OPC_W]
operand_addr_mode  out  MODE_W  next field down
operand_addr  out  ADDR_W  next field down
branch_offset_value  out  BOFS_W  instruction[OFS_W-1:0] sign-extended
illegal  out  1  opcode >= NUM_OPCODES (optional feature; else 0)
start  out  1  sticky: high from first accepted word until reset
occupancy  out  $clog2(DEPTH+1)  words in FIFO, output stage excluded

Behaviour:
- Reset (async assert, sync-safe release): all outputs 0, instr_ready 1 once rst_n high, FIFO pointers/count 0, output stage empty. Reset mid-transfer drops everything.
- Accept: push when instr_valid && instr_ready && !flush. Pop output stage: dec_valid && dec_ready.
- Output stage load (fields decoded at load, registered): loads when empty or popped this cycle. Source priority: FIFO head if occupancy>0, else bypass of word being accepted this cycle. Latency: word accepted in cycle N into empty block -> dec_valid in N+1.
- FIFO: read/write pointers log2(DEPTH) bits, wrap naturally at DEPTH-1 -> 0; count tracks fill. Push into full never occurs (instr_ready=0). Push and pop same cycle when full-minus-zero: pop frees entry only next cycle; ready does not combinationally depend on dec_ready.
- Simultaneous push+refill with FIFO non-empty: head goes to output stage, new word to tail; occupancy unchanged.
- Output fields hold when dec_valid && !dec_ready (stall); no field changes while stalled.
- flush: highest priority. Next cycle: occupancy 0, dec_valid 0, pointers reset to 0; word offered in the flush cycle dropped, no handshake completes. start unaffected. Field outputs keep last value (don't-care when dec_valid=0).
- start: set in cycle after first accepted word; cleared only by rst_n.
- Sign extension: branch_offset_value = {{(BOFS_W-OFS_W){ofs[OFS_W-1]}}, ofs}.

Optional Feature:
ILLEGAL_OPCODE_CHECK_EN: defined -> illegal registered with fields, 1 when opcode >= NUM_OPCODES; word still delivered (downstream traps). Undefined -> illegal tied 0, NUM_OPCODES unused.

Decomposition:
- Package instr_decode_pkg: default field widths, INSTR_W localparam function, field-slice/sign-extend functions, decoded-instruction struct typedef.
- One sub-module: sync_fifo (DEPTH, WIDTH), storing raw words; decode/output stage stays in top.

Test Plan:
- Reset then push 15'b10101_10_0110_1001 -> next cycle dec_valid=1, opcode=0x15, mode=2, addr=6, branch_offset_value=8'hF9, start=1.
- Offset 4'b0111 -> branch_offset_value=8'h07; offset 4'b1000 -> 8'hF8.
- dec_ready=0, push 5 words (DEPTH=4) -> output holds word0, occupancy=4, instr_ready=0; release dec_ready -> words 1..4 in order, one per cycle, no loss/duplication, pointers wrap.
- Push continuous stream with dec_ready=1 -> one dec_valid per cycle, occupancy stays 0 (bypass).
- Fill 3 words, assert flush with instr_valid=1 -> next cycle dec_valid=0, occupancy=0, flushed word never appears; start stays 1.
- With ILLEGAL_OPCODE_CHECK_EN: opcode 23 -> illegal=0; opcode 24 -> illegal=1 with dec_valid=1. Assert rst_n=0 mid-stream -> all outputs 0 immediately.
